cci_mpf_shim_buffer_afu: RTL
============================

Name: cci_mpf_shim_buffer_afu

Overview:
- AFU-side buffering primitive: accepts TX requests from an AFU on c0 (reads) and c1 (writes and interrupts), stores each channel in its own FIFO, and drains toward the QLP under QLP almost-full flow control.
- Generates its own almost-full toward the AFU so the AFU may keep issuing for THRESHOLD cycles after assertion.
- RX responses pass through toward the AFU as wires.
- Sits between a shim's AFU-facing port and its internal logic, giving the shim a registered, flow-controlled request stream.

Parameters:
- DEPTH, 8, entries per channel FIFO; power of 2, at least 4.
- THRESHOLD, 4, free slots remaining when AFU almost-full asserts; 1 to DEPTH-1.
- C0_HDR_W, 74, c0 TX header width.
- C1_HDR_W, 80, c1 TX header width.
- DATA_W, 512, c1 TX data width.
- RX_W, 600, width of each packed RX channel word.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- afu_c0TxHdr  in  C0_HDR_W  AFU read request header.
- afu_c0TxRdValid  in  1  AFU read request valid.
- afu_c0TxAlmFull  out  1  c0 almost-full toward AFU.
- afu_c1TxHdr  in  C1_HDR_W  AFU write/interrupt header.
- afu_c1TxData  in  DATA_W  AFU write data.
- afu_c1TxWrValid  in  1  write valid.
- afu_c1TxIrValid  in  1  interrupt valid.
- afu_c1TxAlmFull  out  1  c1 almost-full toward AFU.
- qlp_c0TxHdr  out  C0_HDR_W  read header toward QLP.
- qlp_c0TxRdValid  out  1  read valid toward QLP.
- qlp_c0TxAlmFull  in  1  QLP c0 almost-full.
- qlp_c1TxHdr  out  C1_HDR_W  c1 header toward QLP.
- qlp_c1TxData  out  DATA_W  write data toward QLP.
- qlp_c1TxWrValid  out  1  write valid toward QLP.
- qlp_c1TxIrValid  out  1  interrupt valid toward QLP.
- qlp_c1TxAlmFull  in  1  QLP c1 almost-full.
- qlp_c0Rx, qlp_c1Rx  in  RX_W  RX from QLP.
- afu_c0Rx, afu_c1Rx  out  RX_W  RX toward AFU; combinational copies.
- error  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and counts go to 0.
  - All qlp_*Valid go to 0.
  - afu_c0TxAlmFull and afu_c1TxAlmFull go to 1.
  - error goes to 0.
  - qlp header and data registers are don't-care.
  - Reset asserted mid-operation discards all queued entries; no partial request is emitted.
- Channels c0 and c1 are fully independent and identical in structure.
- The c1 entry is {hdr, data, wr, ir}.
- Enqueue:
  - A valid input in cycle k is written at the edge ending k.
  - Enqueue is accepted if count < DEPTH, or if count == DEPTH and a pop occurs at the same edge.
  - Otherwise the request is dropped and error sets.
- Protocol errors:
  - afu_c1TxWrValid and afu_c1TxIrValid both high in one cycle sets error.
  - In that case the entry is stored as a write only.
- Dequeue, registered, evaluated per edge:
  - If count > 0 and qlp_cXTxAlmFull == 0 in the current cycle, the head is loaded into the qlp output registers, valid is set to 1, and the head is popped.
  - Otherwise valid goes to 0 and the header/data registers hold.
  - At most one request per channel per cycle.
- Latency: input valid in cycle k produces earliest output valid in cycle k+2. Sustained throughput is 1 per cycle per channel while QLP almost-full is low.
- QLP almost-full is honoured in the cycle it is high; no pop occurs in that cycle. The output already registered may still issue, which the QLP tolerates.
- Almost-full toward AFU:
  - Registered: afu_cXTxAlmFull <= (count_next >= DEPTH-THRESHOLD).
  - count_next includes this edge's push and pop.
  - It deasserts at the first edge after reset release.
- Simultaneous push and pop leave count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- error clears only on reset.

Test Plan:
- Reset, then one c0 read with hdr=0x15 in cycle 3, QLP almFull low -> qlp_c0TxRdValid=1 with hdr 0x15 in cycle 5 only; afu_c0TxAlmFull=1 during reset, 0 from the first edge after release.
- Hold qlp_c1TxAlmFull=1 and issue 8 writes with data=i -> afu_c1TxAlmFull rises at the edge writing the 4th entry; no qlp valid. Release almFull -> 8 consecutive writes, data 0..7 in order; almFull falls when count_next drops below 4.
- Full c0 FIFO (8 entries) with QLP blocked, plus a 9th read -> the 9th is dropped and error=1. Unblock -> exactly 8 reads emerge.
- Full c1 FIFO, QLP unblocked, and a new write in the same cycle as a pop -> accepted, error stays 0, and all entries emerge in order.
- Write and interrupt valid together with hdr=0x2A -> error=1; the output emerges with WrValid=1, IrValid=0.
- Assert reset_n low mid-drain with 5 entries queued -> outputs clear immediately; after release, no stale request appears; RX words pass through unchanged in the same cycle throughout.

Source files
------------

// File: rtl/cci_mpf_shim_buffer_afu.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_buffer_afu
//
// AFU-side TX request buffer. Read requests (c0) and write/interrupt requests
// (c1) are each queued in their own FIFO and drained toward the QLP one per
// cycle whenever the QLP's almost-full for that channel is low. The buffer
// drives its own registered almost-full back to the AFU so the AFU can keep
// issuing for THRESHOLD more cycles after it rises. RX responses are plain
// wires from the QLP side to the AFU side.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   afu_c0Tx*                 read request from the AFU, almost-full back
//   afu_c1Tx*                 write/interrupt request from the AFU, almost-full back
//   qlp_c0Tx*                 registered read request toward the QLP, almost-full in
//   qlp_c1Tx*                 registered write/interrupt toward the QLP, almost-full in
//   qlp_c0Rx, qlp_c1Rx        RX words from the QLP
//   afu_c0Rx, afu_c1Rx        RX words toward the AFU (combinational copies)
//   error                     sticky: overflow drop or write+interrupt together
// ---------------------------------------------------------------------------

// One channel: FIFO storage, registered output stage and AFU almost-full.
//   push/push_entry     request to enqueue this cycle
//   out_alm_full        downstream almost-full; blocks the pop in this cycle
//   out_valid/out_entry registered head entry toward the QLP
//   in_alm_full         registered almost-full toward the AFU
//   overflow            push arrived with no room (combinational)
module cci_mpf_shim_buffer_fifo #(
  parameter int DEPTH     = 8,
  parameter int THRESHOLD = 4,
  parameter int ENTRY_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               out_alm_full,
  output logic               out_valid,
  output logic [ENTRY_W-1:0] out_entry,
  output logic               in_alm_full,
  output logic               overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - THRESHOLD);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic               alm_full_q, alm_full_d;
  logic               pop;
  logic               accept;

  always_comb begin
    // A full FIFO still accepts when the head leaves at the same edge.
    pop      = (count_q != '0) && !out_alm_full;
    accept   = push && ((count_q != FULL_CNT) || pop);
    overflow = push && !accept;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop;
    entry_d  = entry_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      entry_d  = mem_q[rd_ptr_q];
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end

    // Looks at the post-edge occupancy so the AFU sees the flag the cycle
    // the threshold is crossed.
    alm_full_d = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      alm_full_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      alm_full_q <= alm_full_d;
    end
  end

  // Storage and the output payload carry no reset; only the control above
  // decides whether they mean anything.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    if (accept) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign out_valid   = valid_q;
  assign out_entry   = entry_q;
  assign in_alm_full = alm_full_q;

endmodule

module cci_mpf_shim_buffer_afu #(
  parameter int DEPTH     = 8,
  parameter int THRESHOLD = 4,
  parameter int C0_HDR_W  = 74,
  parameter int C1_HDR_W  = 80,
  parameter int DATA_W    = 512,
  parameter int RX_W      = 600
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [C0_HDR_W-1:0] afu_c0TxHdr,
  input  logic                afu_c0TxRdValid,
  output logic                afu_c0TxAlmFull,

  input  logic [C1_HDR_W-1:0] afu_c1TxHdr,
  input  logic [DATA_W-1:0]   afu_c1TxData,
  input  logic                afu_c1TxWrValid,
  input  logic                afu_c1TxIrValid,
  output logic                afu_c1TxAlmFull,

  output logic [C0_HDR_W-1:0] qlp_c0TxHdr,
  output logic                qlp_c0TxRdValid,
  input  logic                qlp_c0TxAlmFull,

  output logic [C1_HDR_W-1:0] qlp_c1TxHdr,
  output logic [DATA_W-1:0]   qlp_c1TxData,
  output logic                qlp_c1TxWrValid,
  output logic                qlp_c1TxIrValid,
  input  logic                qlp_c1TxAlmFull,

  input  logic [RX_W-1:0]     qlp_c0Rx,
  input  logic [RX_W-1:0]     qlp_c1Rx,
  output logic [RX_W-1:0]     afu_c0Rx,
  output logic [RX_W-1:0]     afu_c1Rx,

  output logic                error
);

  localparam int C1_ENTRY_W = C1_HDR_W + DATA_W + 2;

  logic                  c0_overflow;
  logic                  c1_push;
  logic                  c1_both;
  logic [C1_ENTRY_W-1:0] c1_push_entry;
  logic                  c1_out_valid;
  logic [C1_ENTRY_W-1:0] c1_out_entry;
  logic                  c1_overflow;
  logic                  c1_out_wr;
  logic                  c1_out_ir;
  logic                  error_q, error_d;

  // c1 entry layout is {hdr, data, wr, ir}. A simultaneous write and
  // interrupt is a protocol error and is kept as the write alone.
  always_comb begin
    c1_both       = afu_c1TxWrValid && afu_c1TxIrValid;
    c1_push       = afu_c1TxWrValid || afu_c1TxIrValid;
    c1_push_entry = {afu_c1TxHdr, afu_c1TxData, afu_c1TxWrValid,
                     afu_c1TxIrValid && !afu_c1TxWrValid};
    error_d       = error_q || c0_overflow || c1_overflow || c1_both;
  end

  cci_mpf_shim_buffer_fifo #(
    .DEPTH     (DEPTH),
    .THRESHOLD (THRESHOLD),
    .ENTRY_W   (C0_HDR_W)
  ) u_c0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (afu_c0TxRdValid),
    .push_entry   (afu_c0TxHdr),
    .out_alm_full (qlp_c0TxAlmFull),
    .out_valid    (qlp_c0TxRdValid),
    .out_entry    (qlp_c0TxHdr),
    .in_alm_full  (afu_c0TxAlmFull),
    .overflow     (c0_overflow)
  );

  cci_mpf_shim_buffer_fifo #(
    .DEPTH     (DEPTH),
    .THRESHOLD (THRESHOLD),
    .ENTRY_W   (C1_ENTRY_W)
  ) u_c1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (c1_push),
    .push_entry   (c1_push_entry),
    .out_alm_full (qlp_c1TxAlmFull),
    .out_valid    (c1_out_valid),
    .out_entry    (c1_out_entry),
    .in_alm_full  (afu_c1TxAlmFull),
    .overflow     (c1_overflow)
  );

  // The payload register holds after the valid drops, so the request-type
  // bits must be qualified by the output valid.
  assign {qlp_c1TxHdr, qlp_c1TxData, c1_out_wr, c1_out_ir} = c1_out_entry;
  assign qlp_c1TxWrValid = c1_out_valid && c1_out_wr;
  assign qlp_c1TxIrValid = c1_out_valid && c1_out_ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error    = error_q;
  assign afu_c0Rx = qlp_c0Rx;
  assign afu_c1Rx = qlp_c1Rx;

endmodule
